// File: rtl/nv_nvdla_hls_scale_shift_pipe.sv
// Two-stage signed scale / round / arithmetic-shift pipe ahead of the saturate stage.
// Stage 1 registers data*scale together with its shift amount. Stage 2 applies
// round-half-toward-+inf and the arithmetic right shift at full output precision.
// Valid/ready on both sides, bubble-collapsing, one beat per cycle.
module nv_nvdla_hls_scale_shift_pipe #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SCALE_WIDTH = 16,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned OUT_WIDTH   = 49
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SCALE_WIDTH-1:0] in_scale,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [OUT_WIDTH-1:0]   out_data
);

  localparam int unsigned PROD_WIDTH = DATA_WIDTH + SCALE_WIDTH;

  // Stage 1 state: product, its shift amount and the stage valid.
  logic signed [PROD_WIDTH-1:0]  r_s1_prod;
  logic        [SHIFT_WIDTH-1:0] r_s1_shift;
  logic                          r_s1_vld;

  // Stage 2 state: final result and output valid.
  logic        [OUT_WIDTH-1:0]   r_out_data;
  logic                          r_out_pvld;

  // Handshake and datapath wires.
  logic                          w_s2_rdy;
  logic                          w_s1_rdy;
  logic                          w_in_xfer;
  logic                          w_s1_to_s2;
  logic signed [PROD_WIDTH-1:0]  w_prod;
  logic signed [OUT_WIDTH-1:0]   w_ext;
  logic signed [OUT_WIDTH-1:0]   w_rnd;
  logic signed [OUT_WIDTH-1:0]   w_sum;
  logic signed [OUT_WIDTH-1:0]   w_res;

  // Ready chain: a stage accepts when it is empty or its content leaves this edge.
  assign w_s2_rdy   = !r_out_pvld || out_prdy;
  assign w_s1_rdy   = !r_s1_vld || w_s2_rdy;
  assign w_in_xfer  = in_pvld && w_s1_rdy;
  assign w_s1_to_s2 = r_s1_vld && w_s2_rdy;

  assign in_prdy  = w_s1_rdy;
  assign out_pvld = r_out_pvld;
  assign out_data = r_out_data;

  // Full-precision signed product; both operands are sign-extended before the multiply.
  assign w_prod = PROD_WIDTH'($signed(in_data)) * PROD_WIDTH'($signed(in_scale));

  // Round-half-up then arithmetic shift; the sum has headroom so it never overflows.
  always_comb begin
    w_ext = OUT_WIDTH'(r_s1_prod);
    w_rnd = '0;
    if (r_s1_shift != '0) begin
      w_rnd = OUT_WIDTH'(1) << (r_s1_shift - SHIFT_WIDTH'(1));
    end
    w_sum = w_ext + w_rnd;
    w_res = (r_s1_shift == '0) ? w_ext : (w_sum >>> r_s1_shift);
  end

  // Stage 1: load on an input transfer, otherwise empty out once content moves on.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_shift <= '0;
    end else if (w_in_xfer) begin
      r_s1_vld   <= 1'b1;
      r_s1_prod  <= w_prod;
      r_s1_shift <= in_shift;
    end else if (w_s2_rdy) begin
      r_s1_vld   <= 1'b0;
    end
  end

  // Stage 2: load from stage 1 when allowed, otherwise drop valid on an output transfer.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_out_pvld <= 1'b0;
      r_out_data <= '0;
    end else if (w_s1_to_s2) begin
      r_out_pvld <= 1'b1;
      r_out_data <= w_res;
    end else if (out_prdy) begin
      r_out_pvld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_hls_scale_shift_pipe.sv
// Directed bench for the scale/round/shift pipe: reset, rounding, extremes,
// streaming against a reference model, backpressure and reset mid-flight.
module tb_nv_nvdla_hls_scale_shift_pipe;

  logic        clk;
  logic        rst;
  logic        in_pvld;
  logic        in_prdy;
  logic [31:0] in_data;
  logic [15:0] in_scale;
  logic [4:0]  in_shift;
  logic        out_pvld;
  logic        out_prdy;
  logic [48:0] out_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] sd [100];
  logic [15:0] ss [100];
  logic [4:0]  sh [100];
  logic [63:0] se [100];

  nv_nvdla_hls_scale_shift_pipe dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .in_pvld        (in_pvld),
    .in_prdy        (in_prdy),
    .in_data        (in_data),
    .in_scale       (in_scale),
    .in_shift       (in_shift),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_data       (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncate a signed value to the 49-bit output encoding, zero-padded to 64.
  function automatic logic [63:0] to49(input longint v);
    logic [63:0] t;
    t = 64'(v);
    return {15'b0, t[48:0]};
  endfunction

  // Reference: product, then round-half-toward-+inf and arithmetic shift.
  function automatic logic [63:0] model(input logic [31:0] d, input logic [15:0] s,
                                        input logic [4:0] k);
    longint p;
    longint r;
    p = longint'($signed(d)) * longint'($signed(s));
    if (k == 5'd0) r = p;
    else           r = (p + (longint'(1) <<< (k - 5'd1))) >>> k;
    return to49(r);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] s,
                       input logic [4:0] k);
    in_pvld  = v;
    in_data  = d;
    in_scale = s;
    in_shift = k;
  endtask

  initial begin
    rst = 1'b1;
    out_prdy = 1'b1;
    drive(1'b1, 32'd5, 16'd1, 5'd0);

    // Reset held two cycles with a valid offered.
    step();
    step();
    check("rst_pvld", 64'(out_pvld), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_prdy", 64'(in_prdy), 64'd1);
    rst = 1'b0;
    drive(1'b0, 32'd0, 16'd0, 5'd0);
    step();
    step();
    check("rst_no_beat", 64'(out_pvld), 64'd0);

    // Basic rounding: 3 -> 2, -3 -> -1 with shift 1.
    drive(1'b1, 32'd3, 16'd1, 5'd1);
    step();
    check("lat_not_yet", 64'(out_pvld), 64'd0);
    drive(1'b1, 32'hFFFF_FFFD, 16'd1, 5'd1);
    step();
    check("rnd_pos_vld", 64'(out_pvld), 64'd1);
    check("rnd_pos", 64'(out_data), 64'd2);
    drive(1'b0, 32'd0, 16'd0, 5'd0);
    step();
    check("rnd_neg_vld", 64'(out_pvld), 64'd1);
    check("rnd_neg", 64'(out_data), 64'h0001_FFFF_FFFF_FFFF);
    step();
    check("rnd_drain", 64'(out_pvld), 64'd0);

    // Extremes.
    drive(1'b1, 32'h8000_0000, 16'h8000, 5'd0);
    step();
    drive(1'b1, 32'h7FFF_FFFF, 16'h7FFF, 5'd31);
    step();
    check("ext_min", 64'(out_data), 64'h0000_4000_0000_0000);
    drive(1'b0, 32'd0, 16'd0, 5'd0);
    step();
    check("ext_max", 64'(out_data), 64'h0000_0000_0000_7FFF);
    step();

    // Streaming: 100 back-to-back random beats.
    for (int i = 0; i < 100; i++) begin
      sd[i] = $urandom;
      ss[i] = 16'($urandom);
      sh[i] = 5'($urandom_range(31, 0));
      se[i] = model(sd[i], ss[i], sh[i]);
    end
    for (int c = 0; c <= 100; c++) begin
      if (c < 100) drive(1'b1, sd[c], ss[c], sh[c]);
      else         drive(1'b0, 32'd0, 16'd0, 5'd0);
      #1;
      if (c < 100) check("str_prdy", 64'(in_prdy), 64'd1);
      step();
      if (c >= 1) begin
        check("str_vld", 64'(out_pvld), 64'd1);
        check("str_data", 64'(out_data), se[c-1]);
      end
    end
    step();
    check("str_drain", 64'(out_pvld), 64'd0);

    // Backpressure: A=10*3>>0=30, B=round(-14/2)=-7, C=round(-500/8)=-62.
    drive(1'b1, 32'd10, 16'd3, 5'd0);
    step();
    drive(1'b1, 32'd7, 16'hFFFE, 5'd1);
    out_prdy = 1'b0;
    step();
    drive(1'b1, 32'hFFFF_FF9C, 16'd5, 5'd3);
    #1;
    check("bp_prdy", 64'(in_prdy), 64'd0);
    check("bp_vld", 64'(out_pvld), 64'd1);
    check("bp_a", 64'(out_data), to49(30));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_prdy", 64'(in_prdy), 64'd0);
      check("bp_hold_vld", 64'(out_pvld), 64'd1);
      check("bp_hold_a", 64'(out_data), to49(30));
    end
    out_prdy = 1'b1;
    #1;
    check("bp_prdy_rise", 64'(in_prdy), 64'd1);
    step();
    drive(1'b0, 32'd0, 16'd0, 5'd0);
    check("bp_b_vld", 64'(out_pvld), 64'd1);
    check("bp_b", 64'(out_data), to49(-7));
    step();
    check("bp_c_vld", 64'(out_pvld), 64'd1);
    check("bp_c", 64'(out_data), to49(-62));
    step();
    check("bp_drain", 64'(out_pvld), 64'd0);

    // Reset mid-flight: two beats in flight are discarded.
    out_prdy = 1'b0;
    drive(1'b1, 32'd11, 16'd11, 5'd0);
    step();
    drive(1'b1, 32'd22, 16'd22, 5'd0);
    step();
    drive(1'b0, 32'd0, 16'd0, 5'd0);
    check("mf_full", 64'(out_pvld), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_prdy = 1'b1;
    check("mf_rst_vld", 64'(out_pvld), 64'd0);
    check("mf_rst_prdy", 64'(in_prdy), 64'd1);
    step();
    check("mf_gone1", 64'(out_pvld), 64'd0);
    step();
    check("mf_gone2", 64'(out_pvld), 64'd0);
    drive(1'b1, 32'hFFFF_FFFF, 16'hFFFF, 5'd0);
    step();
    drive(1'b0, 32'd0, 16'd0, 5'd0);
    check("mf_lat", 64'(out_pvld), 64'd0);
    step();
    check("mf_new_vld", 64'(out_pvld), 64'd1);
    check("mf_new", 64'(out_data), 64'd1);
    step();
    check("mf_drain", 64'(out_pvld), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_hls_scale_shift_pipe.md
# nv_nvdla_hls_scale_shift_pipe

Pipelined signed scale/round/shift stage that feeds `NV_NVDLA_HLS_saturate`. It multiplies a signed data word by a signed per-transaction scale, then rounds and arithmetic-right-shifts the product by a per-transaction shift. It emits the full-precision result (default 49 bits), which the downstream saturate instance clamps to 32 bits. It sits in the output-conversion path of a processing pipe, between the accumulator/adder stage and the saturate/truncate stage, with valid/ready flow control on both sides.

## Interface
Parameters:
- `DATA_WIDTH`, 32: signed input data width.
- `SCALE_WIDTH`, 16: signed scale width.
- `SHIFT_WIDTH`, 5: unsigned shift-amount width; legal shifts are 0..2^SHIFT_WIDTH-1.
- `OUT_WIDTH`, 49: result width. Must equal DATA_WIDTH+SCALE_WIDTH+1, which matches the saturate `IN_WIDTH` default.

Ports:
- **Clock and reset.** The block uses one clock. Reset is synchronous and active-high.
  - `nvdla_core_clk`, in, 1: core clock.
  - `nvdla_core_rst`, in, 1: synchronous, active-high reset.
- **Input channel:**
  - `in_pvld`, in, 1: input transaction valid.
  - `in_prdy`, out, 1: input ready.
  - `in_data`, in, DATA_WIDTH: signed data.
  - `in_scale`, in, SCALE_WIDTH: signed scale, sampled with `in_data`.
  - `in_shift`, in, SHIFT_WIDTH: unsigned right-shift, sampled with `in_data`.
- **Output channel:**
  - `out_pvld`, out, 1: result valid.
  - `out_prdy`, in, 1: downstream ready.
  - `out_data`, out, OUT_WIDTH: signed rounded, shifted result, intended as the saturate `data_in`.

## Operation
- **Transfer rule.** A transfer occurs on a channel when `pvld` and `prdy` are both 1 at a rising clock edge.
- **Stage 1 (S1), multiply.** On an input transfer, S1 registers:
  - the product `in_data * in_scale` as a signed value of DATA_WIDTH+SCALE_WIDTH bits;
  - `in_shift`;
  - valid `s1_vld` = 1.
- **Stage 2 (S2), round and shift.**
  - Sign-extend the product to OUT_WIDTH.
  - If shift = 0, the result is the product unchanged.
  - Otherwise, add 2^(shift-1), then arithmetic-right-shift by `shift`. This is round-half-toward-+inf.
  - The add is done in OUT_WIDTH bits and cannot overflow (|product| ≤ 2^46 and the rounding term ≤ 2^30 at the defaults).
  - S2 registers the result into `out_data` and sets `out_pvld` = 1.
- **Shift binding.** Shift and scale travel with their own data beat. Changing `in_shift`/`in_scale` between beats never affects beats already in flight.
- **Flow control** (bubble-collapsing, full throughput):
  - `s2_rdy` = !`out_pvld` | `out_prdy`.
  - `s1_rdy` = !`s1_vld` | `s2_rdy`.
  - `in_prdy` = `s1_rdy`.
- **Stage updates.**
  - S1 loads on an input transfer.
  - Otherwise, S1 clears `s1_vld` when its content moves to S2.
  - S2 loads when `s1_vld` & `s2_rdy`.
  - Otherwise, S2 clears `out_pvld` on an output transfer.
- **Ordering and capacity.** No reordering, dropping or duplication. Up to 2 beats are in flight.
- **Output stability.** While `out_pvld`=1 and `out_prdy`=0, `out_data` and `out_pvld` hold stable.
- **No internal FSM.** State is only the two stage valids plus datapath registers.

## Timing
- **Latency.** Input transfer at edge N gives `out_pvld`=1 after edge N+1 (2 registered stages), provided no backpressure.
- **Throughput.** 1 beat/cycle with `out_prdy` held at 1.
- **Full pipe** (both valids = 1, `out_prdy`=0):
  - `in_prdy`=0 in the same cycle (combinational path from `out_prdy`).
  - `in_prdy` rises in the same cycle `out_prdy` rises.
- **Simultaneous events.** Output transfer, S1→S2 move and input transfer may all occur on one edge; all three must take effect.
- **Reset.**
  - While `nvdla_core_rst`=1 at an edge: `s1_vld`, `out_pvld`, `out_data` and the S1 registers go to 0.
  - `in_prdy` reads 1 after reset (the pipe is empty).
  - Reset mid-operation discards all in-flight beats. The first post-reset input sees empty stages.
- **Input handshake.** `in_*` must be stable only while `in_pvld`=1. Input values while `in_pvld`=0 are ignored.

## Test plan
- **Reset state.** Assert reset 2 cycles with `in_pvld`=1 → `out_pvld`=0, `out_data`=0, `in_prdy`=1; no beat emerges after release.
- **Basic rounding.** `in_data`=3, `in_scale`=1, `in_shift`=1 → `out_data`=2. Then `in_data`=-3 (same scale and shift) → `out_data`=-1 (0x1_FFFF_FFFF_FFFF). Each result appears 2 cycles after its input transfer.
- **Extremes.**
  - `in_data`=0x8000_0000, `in_scale`=0x8000, shift 0 → `out_data`=2^46 (0x0_4000_0000_0000).
  - `in_data`=0x7FFF_FFFF, `in_scale`=0x7FFF, shift 31 → `out_data`=0x7FFF (rounded up from 0x7FFE.FFFF…).
- **Streaming.** 100 back-to-back random beats with per-beat random shift, `out_prdy`=1 → 100 outputs in order, 1 per cycle, each matching the reference model (round(data*scale / 2^shift) per the rule above).
- **Backpressure.**
  - Fill the pipe with beats A, B and hold `out_prdy`=0 for 5 cycles → `in_prdy`=0 and `out_data`=A held stable.
  - Release `out_prdy` → A, B, C (C offered during the stall) delivered on consecutive cycles.
- **Reset mid-flight.** With 2 beats in flight, pulse reset 1 cycle → neither beat is ever output; the next input beat appears with 2-cycle latency.
